// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared types and constants for the traffic intersection controller.
//   - phase_e   : controller phases, in the order the normal cycle visits them,
//                 plus FLASH (used only when TRAFFIC_FLASH_EN is defined).
//   - LIGHT_*   : one-hot lamp encodings driven on ns_light / ew_light.
//   - is_allred : true for the two all-red clearance phases.
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_EW = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } phase_e;

    localparam logic [2:0] LIGHT_RED    = 3'b001;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b100;
    localparam logic [2:0] LIGHT_OFF    = 3'b000;

    function automatic logic is_allred(input phase_e p);
        return (p == ALLRED_NS) || (p == ALLRED_EW);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Up-counter measuring time spent in the current phase.
//   Ports:
//     clk, reset : clock and synchronous active-high reset (count -> 0)
//     load       : restart the count at 0 on the next edge (phase entry)
//     len        : length of the current phase in cycles (>= 1)
//     min_len    : minimum-green length in cycles (>= 1)
//     done       : count == len-1, i.e. this is the last cycle of the phase
//     ge_min     : count >= min_len-1, i.e. the minimum time is satisfied
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic [CNT_W-1:0] min_len,
    output logic             done,
    output logic             ge_min
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = load ? '0 : count_q + CNT_W'(1);
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done   = (count_q == len - CNT_W'(1));
    assign ge_min = (count_q >= min_len - CNT_W'(1));

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_intersection_ctrl
//   Two-road (NS/EW) intersection controller with all-red clearance and a
//   latched pedestrian request. A pending request cuts the current green short
//   once the minimum green has elapsed and turns the next all-red into a walk
//   phase of (ALLRED_SEC+WALK_SEC) seconds with walk asserted throughout.
//
//   Optional feature, macro TRAFFIC_FLASH_EN: night-flash mode. flash_req is
//   sampled as an all-red phase ends; when high the controller flashes NS
//   yellow / EW red until flash_req drops, then returns through ALLRED_NS.
//   Without the macro, flash_req is ignored.
//
//   Ports:
//     clk        clock
//     reset      synchronous, active-high reset
//     ped_req    pedestrian button (single-cycle pulse is enough)
//     flash_req  night-flash request
//     ns_light   NS lamp (LIGHT_* encoding)
//     ew_light   EW lamp (LIGHT_* encoding)
//     walk       pedestrian walk indicator
//     ped_pend   pedestrian request latched, not yet serviced
// -----------------------------------------------------------------------------
module traffic_intersection_ctrl #(
    parameter int CLOCK_FREQ    = 50,
    parameter int GREEN_SEC     = 50,
    parameter int MIN_GREEN_SEC = 10,
    parameter int YELLOW_SEC    = 5,
    parameter int ALLRED_SEC    = 1,
    parameter int WALK_SEC      = 10,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       flash_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pend
);

    import traffic_pkg::*;

    // Phase lengths in cycles, computed wide so the range check below is exact.
    localparam longint D_GREEN       = longint'(GREEN_SEC) * longint'(CLOCK_FREQ);
    localparam longint D_MIN         = longint'(MIN_GREEN_SEC) * longint'(CLOCK_FREQ);
    localparam longint D_YELLOW      = longint'(YELLOW_SEC) * longint'(CLOCK_FREQ);
    localparam longint D_ALLRED      = longint'(ALLRED_SEC) * longint'(CLOCK_FREQ);
    localparam longint D_ALLRED_WALK = longint'(ALLRED_SEC + WALK_SEC) * longint'(CLOCK_FREQ);
    localparam longint D_MAX_GY      = (D_GREEN > D_YELLOW) ? D_GREEN : D_YELLOW;
    localparam longint D_MAX         = (D_MAX_GY > D_ALLRED_WALK) ? D_MAX_GY : D_ALLRED_WALK;
    localparam longint D_LIMIT       = (CNT_W >= 63) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                                     : (longint'(1) << CNT_W);

    localparam logic [CNT_W-1:0] LEN_GREEN       = CNT_W'(D_GREEN);
    localparam logic [CNT_W-1:0] LEN_MIN         = CNT_W'(D_MIN);
    localparam logic [CNT_W-1:0] LEN_YELLOW      = CNT_W'(D_YELLOW);
    localparam logic [CNT_W-1:0] LEN_ALLRED      = CNT_W'(D_ALLRED);
    localparam logic [CNT_W-1:0] LEN_ALLRED_WALK = CNT_W'(D_ALLRED_WALK);

    // Elaboration-time parameter checks.
    if (MIN_GREEN_SEC > GREEN_SEC) begin : g_err_min_green
        $fatal(1, "traffic_intersection_ctrl: MIN_GREEN_SEC must not exceed GREEN_SEC");
    end
    if (CLOCK_FREQ < 1 || GREEN_SEC < 1 || MIN_GREEN_SEC < 1 || YELLOW_SEC < 1 ||
        ALLRED_SEC < 1 || WALK_SEC < 1) begin : g_err_min_sec
        $fatal(1, "traffic_intersection_ctrl: all timing parameters must be >= 1");
    end
    if (D_MAX >= D_LIMIT) begin : g_err_cnt_w
        $fatal(1, "traffic_intersection_ctrl: longest phase does not fit in CNT_W");
    end

`ifdef TRAFFIC_FLASH_EN
    localparam logic [CNT_W-1:0] LEN_HALF = CNT_W'(CLOCK_FREQ / 2);

    if (CLOCK_FREQ < 2) begin : g_err_flash
        $fatal(1, "traffic_intersection_ctrl: flash mode needs CLOCK_FREQ >= 2");
    end

    // Lamp blink phase in FLASH: 0 = lit, 1 = dark.
    logic toggle_q, toggle_d;
`else
    // Flash mode is not built; the request input is deliberately unused.
    logic flash_req_unused;
    assign flash_req_unused = flash_req;
`endif

    phase_e           state_q, state_d;
    logic             ped_q, ped_d;
    logic             walk_q, walk_d;
    logic [CNT_W-1:0] timer_len;
    logic             timer_load;
    logic             timer_done;
    logic             timer_ge_min;
    logic             phase_done;
    logic             entering_allred;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .len     (timer_len),
        .min_len (LEN_MIN),
        .done    (timer_done),
        .ge_min  (timer_ge_min)
    );

    // Next-phase logic.
    // NOTE: every signal written here gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        timer_len  = LEN_ALLRED;
        phase_done = 1'b0;
        state_d    = state_q;

        case (state_q)
            ALLRED_NS, ALLRED_EW: begin
                timer_len  = walk_q ? LEN_ALLRED_WALK : LEN_ALLRED;
                phase_done = timer_done;
                if (timer_done) begin
                    state_d = (state_q == ALLRED_NS) ? NS_GREEN : EW_GREEN;
`ifdef TRAFFIC_FLASH_EN
                    if (flash_req) begin
                        state_d = FLASH;
                    end
`endif
                end
            end
            NS_GREEN, EW_GREEN: begin
                timer_len  = LEN_GREEN;
                // Pending pedestrian pre-empts green once the floor is met.
                phase_done = timer_done | (ped_q & timer_ge_min);
                if (phase_done) begin
                    state_d = (state_q == NS_GREEN) ? NS_YELLOW : EW_YELLOW;
                end
            end
            NS_YELLOW: begin
                timer_len  = LEN_YELLOW;
                phase_done = timer_done;
                if (timer_done) begin
                    state_d = ALLRED_EW;
                end
            end
            EW_YELLOW: begin
                timer_len  = LEN_YELLOW;
                phase_done = timer_done;
                if (timer_done) begin
                    state_d = ALLRED_NS;
                end
            end
`ifdef TRAFFIC_FLASH_EN
            FLASH: begin
                // Each timer expiry is a blink boundary; leave only on one.
                timer_len  = LEN_HALF;
                phase_done = timer_done;
                if (timer_done && !flash_req) begin
                    state_d = ALLRED_NS;
                end
            end
`endif
            default: begin
                state_d = ALLRED_NS;
            end
        endcase
    end

    // Pedestrian latch, walk flag and timer restart.
    always_comb begin
        entering_allred = (state_d != state_q) && is_allred(state_d);
        // Restart on every phase change and on each blink boundary in FLASH.
        timer_load      = (state_d != state_q) || phase_done;
        // Set wins over the all-red entry clear, so a press on that very edge
        // is kept for the following all-red.
        ped_d           = ped_req | (ped_q & ~entering_allred);
        // The walk decision is frozen at all-red entry from the pre-edge latch.
        walk_d          = entering_allred ? ped_q
                                          : (is_allred(state_d) ? walk_q : 1'b0);
`ifdef TRAFFIC_FLASH_EN
        toggle_d = 1'b0;
        if (state_q == FLASH && state_d == FLASH) begin
            toggle_d = timer_done ? ~toggle_q : toggle_q;
        end
        if (state_q == FLASH || state_d == FLASH) begin
            ped_d = 1'b0;
        end
`endif
    end

    // NOTE: reset is synchronous and sampled only at the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ALLRED_NS;
            ped_q    <= 1'b0;
            walk_q   <= 1'b0;
`ifdef TRAFFIC_FLASH_EN
            toggle_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ped_q    <= ped_d;
            walk_q   <= walk_d;
`ifdef TRAFFIC_FLASH_EN
            toggle_q <= toggle_d;
`endif
        end
    end

    // Lamp decode straight from the registered phase.
    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = walk_q;
        ped_pend = ped_q;

        case (state_q)
            NS_GREEN:  ns_light = LIGHT_GREEN;
            NS_YELLOW: ns_light = LIGHT_YELLOW;
            EW_GREEN:  ew_light = LIGHT_GREEN;
            EW_YELLOW: ew_light = LIGHT_YELLOW;
`ifdef TRAFFIC_FLASH_EN
            FLASH: begin
                ns_light = toggle_q ? LIGHT_OFF : LIGHT_YELLOW;
                ew_light = toggle_q ? LIGHT_OFF : LIGHT_RED;
            end
`endif
            default: ;
        endcase

        // Lamps show the reset state for as long as reset is held.
        if (reset) begin
            ns_light = LIGHT_RED;
            ew_light = LIGHT_RED;
            walk     = 1'b0;
            ped_pend = 1'b0;
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_intersection_ctrl
//   Self-checking bench for traffic_intersection_ctrl with small timing
//   (CLOCK_FREQ=2, GREEN=4, MIN_GREEN=1, YELLOW=1, ALLRED=1, WALK=2).
//   A phase-schedule model tracks time-in-phase and the pedestrian/flash
//   rules; lamps, walk and ped_pend are compared every cycle, plus directed
//   spot checks of the documented scenarios.
// -----------------------------------------------------------------------------
module tb_traffic_intersection_ctrl;

    localparam int CF  = 2;
    localparam int GS  = 4;
    localparam int MGS = 1;
    localparam int YS  = 1;
    localparam int AS  = 1;
    localparam int WS  = 2;

    localparam int D_G    = GS * CF;
    localparam int D_MIN  = MGS * CF;
    localparam int D_Y    = YS * CF;
    localparam int D_AR   = AS * CF;
    localparam int D_ARW  = (AS + WS) * CF;
    localparam int D_HALF = CF / 2;

`ifdef TRAFFIC_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    // Phase numbering used by the model (a reading of the phase list).
    localparam int P_ARNS = 0, P_NSG = 1, P_NSY = 2, P_AREW = 3, P_EWG = 4, P_EWY = 5, P_FL = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       ped_req;
    logic       flash_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_pend;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .CLOCK_FREQ    (CF),
        .GREEN_SEC     (GS),
        .MIN_GREEN_SEC (MGS),
        .YELLOW_SEC    (YS),
        .ALLRED_SEC    (AS),
        .WALK_SEC      (WS),
        .CNT_W         (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ped_req   (ped_req),
        .flash_req (flash_req),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .walk      (walk),
        .ped_pend  (ped_pend)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_phase   = P_ARNS;
    int m_elapsed = 0;     // cycles already spent in the current phase
    bit m_pend    = 1'b0;
    bit m_walk    = 1'b0;
    bit m_lit     = 1'b1;  // flash lamps lit

    function automatic int phase_len(input int ph, input bit w);
        case (ph)
            P_ARNS, P_AREW: return w ? D_ARW : D_AR;
            P_NSG, P_EWG:   return D_G;
            P_NSY, P_EWY:   return D_Y;
            default:        return D_HALF;
        endcase
    endfunction

    function automatic logic [2:0] exp_ns();
        case (m_phase)
            P_NSG:   return 3'b010;
            P_NSY:   return 3'b100;
            P_FL:    return m_lit ? 3'b100 : 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew();
        case (m_phase)
            P_EWG:   return 3'b010;
            P_EWY:   return 3'b100;
            P_FL:    return m_lit ? 3'b001 : 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    // Advance the model across one clock edge with the inputs seen there.
    task automatic model_step(input bit rst, input bit ped, input bit flash);
        int  nxt;
        bit  ex;
        bit  is_green;
        if (rst) begin
            m_phase = P_ARNS; m_elapsed = 0; m_pend = 0; m_walk = 0; m_lit = 1;
            return;
        end
        is_green = (m_phase == P_NSG) || (m_phase == P_EWG);
        ex = (m_elapsed + 1 >= phase_len(m_phase, m_walk)) ||
             (is_green && m_pend && (m_elapsed + 1 >= D_MIN));
        if (!ex) begin
            m_elapsed++;
            m_pend = (m_phase == P_FL) ? 1'b0 : (m_pend | ped);
            return;
        end
        if (m_phase == P_FL) begin
            if (flash) begin
                m_lit = !m_lit;
                m_elapsed = 0;
                return;
            end
            nxt = P_ARNS;
        end else if (m_phase == P_ARNS || m_phase == P_AREW) begin
            nxt = (FLASH_EN && flash) ? P_FL : m_phase + 1;
        end else begin
            nxt = (m_phase + 1) % 6;
        end
        if (nxt == P_ARNS || nxt == P_AREW) m_walk = (m_phase == P_FL) ? 1'b0 : m_pend;
        else                                 m_walk = 1'b0;
        if (m_phase == P_FL || nxt == P_FL)        m_pend = 1'b0;
        else if (nxt == P_ARNS || nxt == P_AREW)   m_pend = ped;
        else                                       m_pend = m_pend | ped;
        if (nxt == P_FL) m_lit = 1'b1;
        m_phase   = nxt;
        m_elapsed = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, update model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input bit rst, input bit ped, input bit flash);
        reset     = rst;
        ped_req   = ped;
        flash_req = flash;
        @(posedge clk);
        model_step(rst, ped, flash);
        @(negedge clk);
        check("ns_light", {29'd0, ns_light}, {29'd0, exp_ns()});
        check("ew_light", {29'd0, ew_light}, {29'd0, exp_ew()});
        check("walk",     {31'd0, walk},     {31'd0, m_walk});
        check("ped_pend", {31'd0, ped_pend}, {31'd0, m_pend});
    endtask

    // Idle until the model reaches the given phase/time, bounded.
    task automatic run_to(input int ph, input int el, input bit flash, input int budget);
        int k;
        k = 0;
        while (!(m_phase == ph && m_elapsed == el) && k < budget) begin
            step(1'b0, 1'b0, flash);
            k++;
        end
        if (k >= budget && !(m_phase == ph && m_elapsed == el)) begin
            n_checks++;
            n_fail++;
            $error("FAIL run_to: phase %0d/%0d not reached within %0d cycles", ph, el, budget);
        end
    endtask

    int cnt_a, cnt_b;
    bit r_ped, r_rst, r_flash;

    initial begin
        reset = 1'b1; ped_req = 1'b0; flash_req = 1'b0;

        // Reset state.
        step(1, 0, 0);
        step(1, 1, 0);
        check("rst_ns",   {29'd0, ns_light}, 32'h1);
        check("rst_ew",   {29'd0, ew_light}, 32'h1);
        check("rst_walk", {31'd0, walk},     32'h0);
        check("rst_pend", {31'd0, ped_pend}, 32'h0);

        // Free run: one 24-cycle period holds 8 NS and 8 EW green cycles.
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0);
            if (ns_light == 3'b010) cnt_a++;
            if (ew_light == 3'b010) cnt_b++;
        end
        check("period_ns_green", cnt_a, 8);
        check("period_ew_green", cnt_b, 8);

        // Press in NS green cycle 0: green cut to 2, then 6 walk cycles.
        run_to(P_NSG, 0, 0, 40);
        step(0, 1, 0);
        check("ped_latched", {31'd0, ped_pend}, 32'h1);
        cnt_a = 1; cnt_b = 0;
        while (ns_light == 3'b010 && cnt_a < 20) begin
            step(0, 0, 0);
            cnt_a++;
        end
        check("ped_green_len", cnt_a, 2);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0);
            if (walk) cnt_b++;
        end
        check("walk_len", cnt_b, 6);

        // Press on the edge into ALLRED_EW: kept, cuts EW green, walk at ALLRED_NS.
        run_to(P_NSG, 0, 0, 40);
        step(0, 1, 0);
        run_to(P_NSY, 1, 0, 40);
        step(0, 1, 0);
        check("entry_pend", {31'd0, ped_pend}, 32'h1);
        check("entry_walk", {31'd0, walk},     32'h1);
        run_to(P_EWG, 0, 0, 40);
        cnt_a = 0;
        while (ew_light == 3'b010 && cnt_a < 20) begin
            step(0, 0, 0);
            cnt_a++;
        end
        check("cut_ew_green_len", cnt_a, 2);
        run_to(P_ARNS, 0, 0, 40);
        check("next_allred_walk", {31'd0, walk}, 32'h1);

        // Reset mid EW yellow with a pending request.
        run_to(P_EWG, 0, 0, 60);
        step(0, 1, 0);
        run_to(P_EWY, 0, 0, 40);
        check("pre_rst_pend", {31'd0, ped_pend}, 32'h1);
        step(1, 0, 0);
        check("mid_rst_ns",   {29'd0, ns_light}, 32'h1);
        check("mid_rst_ew",   {29'd0, ew_light}, 32'h1);
        check("mid_rst_walk", {31'd0, walk},     32'h0);
        check("mid_rst_pend", {31'd0, ped_pend}, 32'h0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("post_rst_green", {29'd0, ns_light}, 32'h2);

        // Flash request held during NS green, then dropped.
        run_to(P_NSG, 0, 0, 40);
        for (int i = 0; i < 24; i++) step(0, (i == 3), 1);
        if (FLASH_EN) begin
            check("flash_ew_dark_or_red", {31'd0, (ew_light == 3'b001) || (ew_light == 3'b000)}, 32'h1);
        end
        for (int i = 0; i < 20; i++) step(0, 0, 0);

        // Randomised traffic, presses, resets and flash requests.
        r_flash = 1'b0;
        for (int i = 0; i < 800; i++) begin
            r_ped = ($urandom_range(0, 11) == 0);
            r_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) r_flash = !r_flash;
            step(r_rst, r_ped, r_flash);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
